// File: rtl/adj_coo_writer.sv
// Dense adjacency rows in, row-major (row, col) COO entries out to the COO memory write port.
// Optional macro COO_SELF_LOOP_EN forces the diagonal bit set so that A+I is encoded.
module adj_coo_writer #(
   parameter int NUM_OF_NODES    = 6,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
   parameter int NODE_BW         = $clog2(NUM_OF_NODES),
   parameter int NNZ_BW          = $clog2(COO_NUM_OF_COLS + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        adj_row_valid,
   input  logic [NUM_OF_NODES-1:0]     adj_row,
   output logic                        adj_row_ready,
   output logic                        coo_wr_en,
   output logic [COO_BW-1:0]           coo_wr_address,
   output logic [1:0][NODE_BW-1:0]     coo_out,
   output logic [NNZ_BW-1:0]           nnz_count,
   output logic                        overflow,
   output logic                        done
);

   localparam logic [NODE_BW-1:0] LAST_NODE = NODE_BW'(NUM_OF_NODES - 1);
   localparam logic [COO_BW-1:0]  LAST_ADDR = COO_BW'(COO_NUM_OF_COLS - 1);
   localparam logic [NNZ_BW-1:0]  CAPACITY  = NNZ_BW'(COO_NUM_OF_COLS);

   typedef enum logic [1:0] {IDLE, WAIT_ROW, SCAN, DONE} state_t;

   state_t                   state, next_state;
   logic [NUM_OF_NODES-1:0]  scan_row;
   logic [NODE_BW-1:0]       row_idx, col_idx;
   logic [COO_BW-1:0]        address;
   logic                     bit_set, full, last_col, last_row, clear;

`ifdef COO_SELF_LOOP_EN
   assign bit_set = scan_row[col_idx] | (col_idx == row_idx);
`else
   assign bit_set = scan_row[col_idx];
`endif

   assign full     = (nnz_count >= CAPACITY);
   assign last_col = (col_idx == LAST_NODE);
   assign last_row = (row_idx == LAST_NODE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state    = state;
      adj_row_ready = 1'b0;
      clear         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = WAIT_ROW;
               clear      = 1'b1;
            end
         end
         WAIT_ROW: begin
            adj_row_ready = 1'b1;
            if (adj_row_valid) next_state = SCAN;
         end
         SCAN: begin
            if (last_col) next_state = last_row ? DONE : WAIT_ROW;
         end
         DONE: begin
            if (start) begin
               next_state = WAIT_ROW;
               clear      = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_row       <= '0;
         row_idx        <= '0;
         col_idx        <= '0;
         address        <= '0;
         nnz_count      <= '0;
         overflow       <= 1'b0;
         done           <= 1'b0;
         coo_wr_en      <= 1'b0;
         coo_wr_address <= '0;
         coo_out        <= '0;
      end else begin
         coo_wr_en <= 1'b0;
         case (state)
            WAIT_ROW: begin
               if (adj_row_valid) begin
                  scan_row <= adj_row;
                  col_idx  <= '0;
               end
            end
            SCAN: begin
               if (bit_set) begin
                  if (!full) begin
                     coo_wr_en      <= 1'b1;
                     coo_wr_address <= address;
                     coo_out[0]     <= row_idx;
                     coo_out[1]     <= col_idx;
                     nnz_count      <= nnz_count + 1'b1;
                     // address parks on the last slot once memory is full
                     if (address != LAST_ADDR) address <= address + 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               if (last_col) begin
                  if (!last_row) row_idx <= row_idx + 1'b1;
               end else begin
                  col_idx <= col_idx + 1'b1;
               end
            end
            // done lags DONE entry by one cycle so it never coincides with the final write
            DONE: done <= 1'b1;
            default: ;
         endcase
         if (clear) begin
            row_idx   <= '0;
            address   <= '0;
            nnz_count <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adj_coo_writer.sv
// Scoreboard bench for adj_coo_writer: directed matrices, expected COO writes queued by hand.
module tb_adj_coo_writer;

   localparam int N       = 6;
   localparam int CAP     = 6;
   localparam int COO_BW  = 3;
   localparam int NODE_BW = 3;
   localparam int NNZ_BW  = 3;

`ifdef COO_SELF_LOOP_EN
   localparam int SP_NNZ = 6;
   localparam logic SP_OVF = 1'b1;
   localparam int SL_NNZ = 6;
`else
   localparam int SP_NNZ = 5;
   localparam logic SP_OVF = 1'b0;
   localparam int SL_NNZ = 0;
`endif

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic                    adj_row_valid;
   logic [N-1:0]            adj_row;
   logic                    adj_row_ready;
   logic                    coo_wr_en;
   logic [COO_BW-1:0]       coo_wr_address;
   logic [1:0][NODE_BW-1:0] coo_out;
   logic [NNZ_BW-1:0]       nnz_count;
   logic                    overflow;
   logic                    done;

   always #5 clk = ~clk;

   adj_coo_writer #(
      .NUM_OF_NODES(N),
      .COO_NUM_OF_COLS(CAP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .adj_row_valid(adj_row_valid),
      .adj_row(adj_row),
      .adj_row_ready(adj_row_ready),
      .coo_wr_en(coo_wr_en),
      .coo_wr_address(coo_wr_address),
      .coo_out(coo_out),
      .nnz_count(nnz_count),
      .overflow(overflow),
      .done(done)
   );

   int total = 0;
   int bad   = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;

   logic [N-1:0] sparse [6] = '{6'b000010, 6'b000101, 6'b000000,
                                6'b100000, 6'b000000, 6'b010000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int a, input int r, input int c);
      exp_q.push_back({3'(a), 3'(r), 3'(c)});
   endtask

   // expected entry packing: {address, row, col}
   always @(negedge clk) begin
      if (coo_wr_en) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_write: got addr=%0d row=%0d col=%0d expected no write at %0t",
                     coo_wr_address, coo_out[0], coo_out[1], $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("coo_write", {23'd0, coo_wr_address, coo_out[0], coo_out[1]}, {23'd0, mon_exp});
         end
      end
   end

   task automatic push_sparse();
`ifdef COO_SELF_LOOP_EN
      push(0, 0, 0); push(1, 0, 1); push(2, 1, 0);
      push(3, 1, 1); push(4, 1, 2); push(5, 2, 2);
`else
      push(0, 0, 1); push(1, 1, 0); push(2, 1, 2);
      push(3, 3, 5); push(4, 5, 4);
`endif
   endtask

   task automatic start_pulse();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_nnz_clear", nnz_count, 0);
      chk("start_ovf_clear", overflow, 0);
      chk("start_done_clear", done, 0);
      chk("start_ready", adj_row_ready, 1);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!adj_row_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got ready=0 expected 1 within 40 cycles at %0t", $time);
      end
   endtask

   // returns #1 after the accepting posedge
   task automatic send_row(input logic [N-1:0] row, input int stall);
      @(negedge clk);
      adj_row_valid = 1'b0;
      if (stall > 0) begin
         wait_ready();
         for (int i = 0; i < stall; i++) begin
            chk("stall_ready", adj_row_ready, 1);
            @(negedge clk);
         end
      end
      adj_row       = row;
      adj_row_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 adj_row_valid = 1'b0;
   endtask

   task automatic finish_check(input int exp_nnz, input logic exp_ovf);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (j == 6) chk("done_not_early", done, 0);
         if (j == 7) chk("done_rise", done, 1);
      end
      chk("final_nnz", nnz_count, exp_nnz);
      chk("final_ovf", overflow, exp_ovf);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b1; adj_row_valid = 1'b0; adj_row = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en", coo_wr_en, 0);
      chk("rst_addr", coo_wr_address, 0);
      chk("rst_coo_out", coo_out, 0);
      chk("rst_nnz", nnz_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", adj_row_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("start_after_reset", adj_row_ready, 1);
      start = 1'b0;

      // start while in WAIT_ROW is ignored; then the sparse matrix
      start_pulse();
      push_sparse();
      for (int i = 0; i < N; i++) send_row(sparse[i], 0);
      finish_check(SP_NNZ, SP_OVF);

      // same matrix with 3-cycle stalls before each row
      start_pulse();
      push_sparse();
      for (int i = 0; i < N; i++) send_row(sparse[i], 3);
      finish_check(SP_NNZ, SP_OVF);

      // all-ones: only row 0 fits, overflow on row 1 column 0
      start_pulse();
      for (int i = 0; i < N; i++) push(i, 0, i);
      send_row(6'b111111, 0);
      send_row(6'b111111, 0);
      @(negedge clk);
      chk("ovf_before_drop", overflow, 0);
      @(negedge clk);
      chk("ovf_at_drop", overflow, 1);
      for (int i = 2; i < N; i++) send_row(6'b111111, 0);
      finish_check(6, 1'b1);

      // reset while scanning row 1 column 3
      start_pulse();
`ifdef COO_SELF_LOOP_EN
      push(0, 0, 0); push(1, 0, 1); push(2, 1, 0); push(3, 1, 1); push(4, 1, 2);
`else
      push(0, 0, 1); push(1, 1, 0); push(2, 1, 2);
`endif
      send_row(sparse[0], 0);
      send_row(sparse[1], 0);
      for (int j = 0; j < 4; j++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_wr_en", coo_wr_en, 0);
      chk("midrst_addr", coo_wr_address, 0);
      chk("midrst_coo_out", coo_out, 0);
      chk("midrst_nnz", nnz_count, 0);
      chk("midrst_ready", adj_row_ready, 0);
      reset = 1'b0;
      start_pulse();
      push_sparse();
      for (int i = 0; i < N; i++) send_row(sparse[i], 0);
      finish_check(SP_NNZ, SP_OVF);

      // all-zero matrix: self-loops only when the macro is on
      start_pulse();
`ifdef COO_SELF_LOOP_EN
      for (int i = 0; i < N; i++) push(i, i, i);
`endif
      for (int i = 0; i < N; i++) send_row('0, 0);
      finish_check(SL_NNZ, 1'b0);

      repeat (3) @(negedge clk);
      chk("end_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
